// File: rtl/nlprg_9_pkg.sv
// Shared constants for the 9-bit nonlinear pseudo-random generator.
//   NLPRG_W   : state/output width
//   TAP_HI/LO : feedback taps of the x^9 + x^4 + 1 recurrence
//   RST_STATE : state loaded by reset (the all-zero state lies on the cycle)
package nlprg_9_pkg;

  localparam int unsigned NLPRG_W = 9;
  localparam int unsigned TAP_HI  = 8;
  localparam int unsigned TAP_LO  = 4;

  localparam logic [NLPRG_W-1:0] RST_STATE = 9'h000;

endpackage : nlprg_9_pkg

// File: rtl/nlprg_9.sv
// nlprg_9: free-running 9-bit de Bruijn-modified Fibonacci LFSR.
// Visits all 512 states (including zero) in one fixed cycle of 512 clocks.
// Ports:
//   ck  - clock, state advances on rising edge
//   rst - asynchronous active-high reset, forces state to RST_STATE
//   o   - current state, driven straight from the register
module nlprg_9
  import nlprg_9_pkg::*;
(
  input  logic               ck,
  input  logic               rst,
  output logic [NLPRG_W-1:0] o
);

  logic [NLPRG_W-1:0] s_q;
  logic [NLPRG_W-1:0] s_d;
  logic               low_zero;
  logic               fb;

  // The zero detector on the low 8 bits flips the feedback only for 9'h100
  // and 9'h000, splicing the all-zero state in between them: 100 -> 000 -> 001.
  always_comb begin
    low_zero = (s_q[NLPRG_W-2:0] == '0);
    fb       = s_q[TAP_HI] ^ s_q[TAP_LO] ^ low_zero;
    s_d      = {s_q[NLPRG_W-2:0], fb};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value; blocking here would create simulation/synthesis races.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      s_q <= RST_STATE;
    end else begin
      s_q <= s_d;
    end
  end

  assign o = s_q;

endmodule : nlprg_9

// File: tb/tb_nlprg_9.sv
// Self-checking bench for nlprg_9: reset behaviour, opening sequence,
// full 512-clock period, uniqueness, zero-insertion and mid-run reset.
module tb_nlprg_9;

  logic       ck;
  logic       rst;
  logic       ck_en;
  logic [8:0] o;

  int checks;
  int errors;

  nlprg_9 dut (
    .ck  (ck),
    .rst (rst),
    .o   (o)
  );

  initial begin
    ck = 1'b0;
    forever begin
      #5;
      if (ck_en) ck = ~ck;
    end
  end

  typedef struct {
    int         edges;   // rising edges since reset release
    logic [8:0] exp;     // expected o after those edges
  } vec_t;

  vec_t       vecs [10];
  logic [8:0] first_seq [512];
  bit         seen [512];

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ck);
    @(negedge ck);
  endtask

  initial begin
    int   distinct;
    int   early_zero;
    int   found;
    logic [8:0] hand_seq [10];

    checks = 0;
    errors = 0;
    ck_en  = 1'b0;
    rst    = 1'b0;

    hand_seq = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h010,
                 9'h021, 9'h042, 9'h084, 9'h108, 9'h011};
    for (int i = 0; i < 10; i++) begin
      vecs[i].edges = i + 1;
      vecs[i].exp   = hand_seq[i];
    end

    // Reset with clock idle: must act immediately without any ck edge.
    #3 rst = 1'b1;
    #1 check("reset_idle", o, 9'h000);

    ck_en = 1'b1;
    step();
    check("reset_held_edge", o, 9'h000);

    // Release between edges, then walk the opening sequence from the table.
    rst = 1'b0;
    first_seq[0] = o;
    for (int i = 0; i < 10; i++) begin
      step();
      first_seq[vecs[i].edges] = o;
      check($sformatf("seq_edge_%0d", vecs[i].edges), o, vecs[i].exp);
    end

    // Remainder of the period: no zero before edge 512, all values distinct.
    early_zero = 0;
    for (int k = 11; k < 512; k++) begin
      step();
      first_seq[k] = o;
      if (o == 9'h000) early_zero++;
    end
    check("no_early_zero", 9'(early_zero), 9'd0);

    for (int i = 0; i < 512; i++) seen[i] = 1'b0;
    for (int i = 0; i < 512; i++) seen[first_seq[i]] = 1'b1;
    distinct = 0;
    for (int i = 0; i < 512; i++) if (seen[i]) distinct++;
    check("distinct_lo", 9'(distinct), 9'd0);   // 512 wraps to 0 in 9 bits
    check("distinct_nz", {8'd0, (distinct == 512)}, 9'd1);

    step();
    check("period_512_zero", o, 9'h000);

    // Zero insertion: locate 9'h100 (bounded), then expect 000, 001.
    found = 0;
    for (int k = 0; k < 600 && found == 0; k++) begin
      step();
      if (o == 9'h100) found = 1;
    end
    check("found_100", {8'd0, found[0]}, 9'd1);
    step();
    check("zero_ins_100_to_000", o, 9'h000);
    step();
    check("zero_ins_000_to_001", o, 9'h001);

    // Mid-run reset after 200 clocks, asserted between edges.
    for (int k = 0; k < 200; k++) step();
    #2 rst = 1'b1;
    #1 check("midrun_async_reset", o, 9'h000);
    step();
    check("midrun_reset_held", o, 9'h000);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("restart_edge_%0d", i), o, hand_seq[i-1]);
    end
    for (int i = 11; i <= 20; i++) begin
      step();
      check($sformatf("restart_edge_%0d", i), o, first_seq[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_nlprg_9

// File: doc/nlprg_9.md
# nlprg_9

Free-running 9-bit nonlinear pseudo-random generator. It is built as a de Bruijn-modified Fibonacci LFSR, so it visits all 512 states, including all-zero, in a fixed maximal cycle. It serves as a standalone pattern and stimulus source and needs no enable or seed inputs. Its output is the raw register state.

## Interface
- Parameters: none; the width is fixed at 9.
- ck  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- o  output  9  current generator state, driven directly from the register with no combinational path from inputs.

## Operation
- State register s[8:0]; o = s.
- Reset: s = 9'h000 immediately on rst rising, held while rst is high.
- Each rising ck with rst low: s <= {s[7:0], fb}.
- fb = s[8] XOR s[4] XOR z, where z = (s[7:0] == 8'h00).
- Base recurrence a(n+9) = a(n) XOR a(n+4), from characteristic polynomial x^9+x^4+1 (primitive); without z this gives the 511-state cycle over nonzero states.
- The z term inserts the all-zero state:
  - 9'h100 -> 9'h000, where the normal feedback would give 9'h001.
  - 9'h000 -> 9'h001.
  - All other states have s[7:0] != 0, so z = 0 and they are unaffected.
- Resulting sequence is a single 512-state cycle; every 9-bit value appears exactly once per period.
- Period is exactly 512 clocks. Starting from reset, o returns to 9'h000 on the 512th rising edge and never before.
- Start of sequence after reset: 000, 001, 002, 004, 008, 010, 021, 042, 084, 108, 011, …
- No lock-up state exists; any state, including ones reached by upsets, lies on the main cycle.

## Timing
- Latency: o changes one ck edge after rst deasserts. The first edge gives 9'h001.
- Reset mid-operation forces 9'h000 asynchronously. Sequence restarts from the beginning after release.
- Reset deassertion coincident with a ck edge: that edge is not required to advance the state. Integrators synchronize rst release to ck.
- One state advance per clock; no stalls, no enable.
- Wrap-around is free-running: state 512 = state 0, and the cycle continues indefinitely.

## Structure
- Shared package holds:
  - width constant NLPRG_W = 9.
  - tap constants: 8 and 4.
  - reset state constant 9'h000.
- Single flat module containing the register, XOR feedback and zero detector on s[7:0]; no sub-module.
- Optional self-check assertions (period and uniqueness) live in the bench, not in the RTL.

## Test plan
- Reset value: assert rst with ck idle -> o = 9'h000 immediately, independent of ck.
- First outputs: release rst, apply 10 clocks -> o = 001, 002, 004, 008, 010, 021, 042, 084, 108, 011.
- Full period: run a 9-bit counter alongside from reset. o must not equal 9'h000 while the counter is 1..511, and must equal 9'h000 exactly when the counter wraps to 0 (edge 512).
- Uniqueness: record o over 512 clocks -> all 512 values are distinct and cover 0..511.
- Zero-insertion transitions: from o = 9'h100 the next value is 9'h000; from 9'h000 the next value is 9'h001.
- Mid-run reset: after 200 clocks assert rst asynchronously between edges -> o = 000 at once; after release, the sequence repeats from 001 identically.
